prog_encoder: RTL and testbench
===============================

Name: prog_encoder

Overview:
- Inverse of the pipeline's opcode/funct control decoder. It takes field-level instruction requests (kind, ALU op, register numbers, immediate, jump target) over a valid/ready stream and encodes them into 32-bit MIPS words.
- Encoded words are written sequentially into instruction memory.
- Used as the boot/program loader ahead of the pipelined CPU and by testbenches to build programs without hand-assembled hex.

Parameters:
- AW, 8, instruction-memory word-address width; capacity 2**AW words
- BASE, 0, first word address written after start

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a load at BASE
- in_valid  in  1  request beat valid
- in_ready  out  1  encoder can accept a beat
- in_kind  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=J, 5=ADDI, 6/7 illegal
- in_alu  in  3  ALU code for R-type: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 110 NOR, 111 XOR; 101 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  16  immediate/offset (LW, SW, BEQ, ADDI)
- in_target  in  26  J target field
- in_last  in  1  marks final beat of program
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  AW  word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after last word written
- err  out  1  sticky error flag
- word_count  out  AW+1  words written in current load

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0, imem_we=0, imem_addr=BASE, imem_wdata=0, busy=0, done=0, err=0, word_count=0. Reset mid-load aborts immediately, and no write occurs on the following edge.
- States: IDLE, RUN, FLUSH, ERR.
  - IDLE: on start, go to RUN; clear err and word_count; write pointer = BASE.
  - RUN: in_ready=1 while no error is pending. A beat is accepted when in_valid & in_ready.
  - Accepted beat with in_last=1 and legal encoding: go to FLUSH.
  - FLUSH: one cycle, in_ready=0. Completes the final write, pulses done in the next cycle, then returns to IDLE.
  - ERR: in_ready=0 and err=1. Left only by start (go to RUN, err cleared) or by reset.
  - start is ignored in RUN and FLUSH.
- Latency:
  - Beat accepted at edge N gives imem_we=1 with registered addr and data during cycle N+1.
  - Throughput is one word per cycle.
  - Pointer and word_count increment at the edge that commits the write.
  - done=1 during the cycle after the last imem_we.
- Encoding (op | rs | rt | rd | shamt | funct / imm / target):
  - R: 000000, rs, rt, rd, 00000, funct. funct from in_alu: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, NOR 100111, XOR 100110.
  - LW: 100011, rs, rt, imm.
  - SW: 101011, rs, rt, imm.
  - BEQ: 000100, rs, rt, imm.
  - ADDI: 001000, rs, rt, imm.
  - J: 000010, target.
  - Unused input fields are ignored.
- Illegal beat (in_kind 6/7, or R with in_alu=101): the beat is accepted, no write occurs, err=1, state goes to ERR, and done does not pulse.
- Overflow: accepting a beat when word_count==2**AW-BASE (memory full) causes no write, err=1, and state ERR. Address never wraps.
- A legal beat followed by an illegal one: the legal word is still written at N+1.
- imem_wdata holds its last value when imem_we=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants LW, SW, R, BEQ, J, ADDI
  - funct constants
  - 3-bit ALU-code constants
  - in_kind enumeration
- The control decoder shares the same constants, so the encode and decode tables cannot diverge.
- One natural sub-module: instr_pack, a combinational encoder from fields to {word, illegal}. The FSM, pointer and output registers stay in prog_encoder.

Test Plan:
- Reset mid-load: start, 3 beats streaming, rst_n low after beat 2 accepted -> no further imem_we; all outputs at reset values; after release and a new start, first write is at BASE.
- Basic load: start, then R ADD rs=1 rt=2 rd=3 -> addr 0, 0x00221820; LW rs=0 rt=4 imm=0x0010 -> addr 1, 0x8C040010; SW rs=0 rt=4 imm=0x0014 -> addr 2, 0xAC040014; BEQ rs=4 rt=5 imm=0xFFFF (last) -> addr 3, 0x1085FFFF. Then done pulses one cycle after addr 3 write; word_count=4; back to IDLE.
- J target=0x0000010 and ADDI rs=1 rt=1 imm=0x0005 -> 0x08000010, 0x20210005.
- Back-to-back valid with no bubbles: imem_we high on consecutive cycles and addresses increment by 1. in_valid toggling gives writes only for accepted beats.
- Illegal beat: R with in_alu=101 after one legal beat -> legal word written, no second write, err=1 sticky, in_ready=0. A new start clears err.
- Overflow with AW=2, BASE=0: 5 beats -> 4 writes at addrs 0..3; 5th beat raises err with no write and no done.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants used by both the program encoder and the
// pipeline's control decoder, so the two tables always agree.
package mips_pkg;

    // Primary opcodes (instruction bits 31:26)
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // R-type funct field values (instruction bits 5:0)
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;

    // 3-bit ALU operation codes; 3'b101 has no operation assigned
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    // Instruction kinds carried on a request beat; 6 and 7 are unassigned
    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_BEQ  = 3'd3,
        KIND_J    = 3'd4,
        KIND_ADDI = 3'd5
    } kind_e;

    // Loader control states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_ERR
    } enc_state_e;

    // Maps an ALU code to {legal, funct}; unassigned codes return all zeros
    function automatic logic [6:0] alu_funct(input logic [2:0] alu);
        case (alu)
            ALU_AND: return {1'b1, FN_AND};
            ALU_OR:  return {1'b1, FN_OR};
            ALU_ADD: return {1'b1, FN_ADD};
            ALU_SUB: return {1'b1, FN_SUB};
            ALU_SLT: return {1'b1, FN_SLT};
            ALU_NOR: return {1'b1, FN_NOR};
            ALU_XOR: return {1'b1, FN_XOR};
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer: builds one 32-bit MIPS instruction from
// a request beat and flags encodings that have no legal form.
module instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    logic [6:0] funct_info;

    assign funct_info = alu_funct(alu);

    // Select the instruction format for the requested kind and assemble the word
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (kind)
            KIND_R: begin
                word    = {OP_R, rs, rt, rd, 5'd0, funct_info[5:0]};
                illegal = !funct_info[6];
            end
            KIND_LW:   word = {OP_LW, rs, rt, imm};
            KIND_SW:   word = {OP_SW, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
            KIND_J:    word = {OP_J, target};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/prog_encoder.sv
// Program loader: accepts field-level instruction requests on a valid/ready
// stream, encodes them and writes the words sequentially into instruction
// memory starting at BASE.
module prog_encoder
    import mips_pkg::*;
#(
    parameter int AW   = 8,
    parameter int BASE = 0
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_kind,
    input  logic [2:0]    in_alu,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [4:0]    in_rd,
    input  logic [15:0]   in_imm,
    input  logic [25:0]   in_target,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_count
);

    localparam int            CAP       = (1 << AW) - BASE;
    localparam logic [AW-1:0] BASE_ADDR = AW'(BASE);
    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [AW+1:0] CAP_COUNT = (AW+2)'(CAP);

    enc_state_e    state;
    enc_state_e    state_next;
    logic [31:0]   packed_word;
    logic          packed_illegal;
    logic          accept;
    logic          full;
    logic          do_write;
    logic          go_err;
    logic          do_start;
    logic [AW+1:0] pending_count;

    instr_pack u_pack (
        .kind    (in_kind),
        .alu     (in_alu),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (packed_word),
        .illegal (packed_illegal)
    );

    // Words already committed plus the one currently on the write port; the
    // visible count lags acceptance by a cycle, so fullness must include it.
    assign pending_count = {1'b0, word_count} + {{(AW+1){1'b0}}, imem_we};
    assign full          = (pending_count >= CAP_COUNT);
    assign in_ready      = (state == ST_RUN);
    assign busy          = (state == ST_RUN);
    assign accept        = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the per-cycle write / error / restart decisions
    always_comb begin
        state_next = state;
        do_write   = 1'b0;
        go_err     = 1'b0;
        do_start   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    do_start   = 1'b1;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (packed_illegal || full) begin
                        state_next = ST_ERR;
                        go_err     = 1'b1;
                    end else begin
                        do_write = 1'b1;
                        if (in_last) begin
                            state_next = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                if (start) begin
                    state_next = ST_RUN;
                    do_start   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Write port: a legal accepted beat appears on the memory bus one cycle later; data holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_wdata <= 32'd0;
        end else begin
            imem_we <= do_write;
            if (do_write) begin
                imem_wdata <= packed_word;
            end
        end
    end

    // Write pointer and word count advance when a write commits; start rewinds them; the pointer saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
        end else if (do_start) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
        end else if (imem_we) begin
            word_count <= word_count + (AW+1)'(1);
            if (imem_addr != ADDR_MAX) begin
                imem_addr <= imem_addr + AW'(1);
            end
        end
    end

    // Sticky error flag and the done pulse that follows the flush cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_FLUSH);
            if (go_err) begin
                err <= 1'b1;
            end else if (do_start) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_encoder.sv
// Self-checking bench for prog_encoder: a scoreboard of expected memory writes
// is filled as beats are accepted and drained as the encoder writes.
module tb_prog_encoder;

    localparam int AW   = 8;
    localparam int BASE = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          start     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [2:0]    in_kind   = 3'd0;
    logic [2:0]    in_alu    = 3'd0;
    logic [4:0]    in_rs     = 5'd0;
    logic [4:0]    in_rt     = 5'd0;
    logic [4:0]    in_rd     = 5'd0;
    logic [15:0]   in_imm    = 16'd0;
    logic [25:0]   in_target = 26'd0;
    logic          in_last   = 1'b0;

    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   word_count;

    logic          s_in_ready;
    logic          s_imem_we;
    logic [1:0]    s_imem_addr;
    logic [31:0]   s_imem_wdata;
    logic          s_busy;
    logic          s_done;
    logic          s_err;
    logic [2:0]    s_word_count;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks      = 0;
    int            passed      = 0;
    int            model_count = 0;
    int            done_count  = 0;
    int            done_before = 0;
    int            s_writes    = 0;
    int            s_done_count = 0;
    logic [1:0]    s_last_addr = 2'd0;
    logic          prev_we     = 1'b0;
    logic [AW-1:0] prev_addr   = '0;

    prog_encoder #(.AW(AW), .BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    prog_encoder #(.AW(2), .BASE(0)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_kind(in_kind), .in_alu(in_alu), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .busy(s_busy), .done(s_done), .err(s_err), .word_count(s_word_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference encoder written from the instruction formats: returns {illegal, word}
    function automatic logic [32:0] model_encode(input logic [2:0] kind, input logic [2:0] alu,
                                                 input logic [4:0] rs, input logic [4:0] rt,
                                                 input logic [4:0] rd, input logic [15:0] imm,
                                                 input logic [25:0] target);
        logic [5:0] f;
        f = 6'h00;
        case (kind)
            3'd0: begin
                case (alu)
                    3'd0: f = 6'h24;
                    3'd1: f = 6'h25;
                    3'd2: f = 6'h20;
                    3'd3: f = 6'h22;
                    3'd4: f = 6'h2A;
                    3'd6: f = 6'h27;
                    3'd7: f = 6'h26;
                    default: return {1'b1, 32'd0};
                endcase
                return {1'b0, 6'h00, rs, rt, rd, 5'd0, f};
            end
            3'd1: return {1'b0, 6'h23, rs, rt, imm};
            3'd2: return {1'b0, 6'h2B, rs, rt, imm};
            3'd3: return {1'b0, 6'h04, rs, rt, imm};
            3'd4: return {1'b0, 6'h02, target};
            3'd5: return {1'b0, 6'h08, rs, rt, imm};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Offer one beat, wait (bounded) for acceptance, and queue its expected write
    task automatic applyStimulus(input logic [2:0] kind, input logic [2:0] alu,
                                 input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [15:0] imm, input logic [25:0] target,
                                 input logic last, input logic [32:0] expect_enc);
        int   waited = 0;
        logic rdy;
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_alu    = alu;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = target;
        in_last   = last;
        rdy = in_ready;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            rdy = in_ready;
            waited++;
        end
        if (!rdy) begin
            checkOutput("accept_timeout", 32'(rdy), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            if (!expect_enc[32]) begin
                e.addr = AW'(BASE + model_count);
                e.data = expect_enc[31:0];
                exp_q.push_back(e);
                model_count++;
            end
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic sendModel(input logic [2:0] kind, input logic [2:0] alu,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [15:0] imm, input logic [25:0] target, input logic last);
        applyStimulus(kind, alu, rs, rt, rd, imm, target, last,
                      model_encode(kind, alu, rs, rt, rd, imm, target));
    endtask

    task automatic startLoad();
        @(negedge clk);
        start       = 1'b1;
        model_count = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 10);
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"},   32'(in_ready),   32'd0);
        checkOutput({tag, "_imem_we"},    32'(imem_we),    32'd0);
        checkOutput({tag, "_imem_addr"},  32'(imem_addr),  32'(BASE));
        checkOutput({tag, "_imem_wdata"}, imem_wdata,      32'd0);
        checkOutput({tag, "_busy"},       32'(busy),       32'd0);
        checkOutput({tag, "_done"},       32'(done),       32'd0);
        checkOutput({tag, "_err"},        32'(err),        32'd0);
        checkOutput({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // Write monitor: pops the scoreboard on every write and tracks done pulses on both instances
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (imem_we) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_we", 32'(imem_we), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
                    checkOutput("wr_data", imem_wdata, mon_e.data);
                end
                if (prev_we) begin
                    checkOutput("b2b_addr_step", 32'(imem_addr), 32'(prev_addr) + 32'd1);
                end
            end
            prev_we   = imem_we;
            prev_addr = imem_addr;
            if (done) done_count++;
            if (s_imem_we) begin
                s_writes++;
                s_last_addr = s_imem_addr;
            end
            if (s_done) s_done_count++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic load from the worked example; unused fields carry junk
        startLoad();
        applyStimulus(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h3FFFFFF, 1'b0, {1'b0, 32'h00221820});
        applyStimulus(3'd1, 3'b111, 5'd0, 5'd4, 5'h1F, 16'h0010, 26'h0ABCDEF, 1'b0, {1'b0, 32'h8C040010});
        applyStimulus(3'd2, 3'b000, 5'd0, 5'd4, 5'd7,  16'h0014, 26'h0000001, 1'b0, {1'b0, 32'hAC040014});
        applyStimulus(3'd3, 3'b000, 5'd4, 5'd5, 5'd0,  16'hFFFF, 26'h0000000, 1'b1, {1'b0, 32'h1085FFFF});
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        checkOutput("flush_busy", 32'(busy), 32'd0);
        waitDone("basic_done");
        checkOutput("basic_word_count", 32'(word_count), 32'd4);
        checkOutput("basic_busy_idle", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("wdata_holds", imem_wdata, 32'h1085FFFF);

        // Jump and add-immediate
        startLoad();
        applyStimulus(3'd4, 3'b000, 5'd9, 5'd9, 5'd9, 16'hBEEF, 26'h0000010, 1'b0, {1'b0, 32'h08000010});
        applyStimulus(3'd5, 3'b000, 5'd1, 5'd1, 5'd0, 16'h0005, 26'h0000000, 1'b1, {1'b0, 32'h20210005});
        waitDone("j_addi_done");
        checkOutput("j_addi_word_count", 32'(word_count), 32'd2);

        // Remaining ALU ops back-to-back, then a bubble before the tail
        startLoad();
        sendModel(3'd0, 3'b001, 5'd3,  5'd4,  5'd5,  16'd0, 26'd0, 1'b0);
        sendModel(3'd0, 3'b011, 5'd6,  5'd7,  5'd8,  16'd0, 26'd0, 1'b0);
        sendModel(3'd0, 3'b100, 5'd9,  5'd10, 5'd11, 16'd0, 26'd0, 1'b0);
        @(posedge clk);
        #1;
        sendModel(3'd0, 3'b110, 5'd12, 5'd13, 5'd14, 16'd0, 26'd0, 1'b0);
        sendModel(3'd0, 3'b111, 5'd15, 5'd16, 5'd17, 16'd0, 26'd0, 1'b0);
        sendModel(3'd0, 3'b000, 5'd31, 5'd30, 5'd29, 16'd0, 26'd0, 1'b1);
        waitDone("b2b_done");
        checkOutput("b2b_word_count", 32'(word_count), 32'd6);

        // Illegal ALU code after one legal beat
        startLoad();
        done_before = done_count;
        applyStimulus(3'd0, 3'b010, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, {1'b0, 32'h00221820});
        applyStimulus(3'd0, 3'b101, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, {1'b1, 32'd0});
        @(negedge clk);
        checkOutput("illegal_err", 32'(err), 32'd1);
        checkOutput("illegal_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("illegal_err_sticky", 32'(err), 32'd1);
        checkOutput("illegal_word_count", 32'(word_count), 32'd1);
        checkOutput("illegal_no_done", 32'(done_count), 32'(done_before));
        startLoad();
        @(negedge clk);
        checkOutput("restart_err_clear", 32'(err), 32'd0);
        checkOutput("restart_busy", 32'(busy), 32'd1);
        applyStimulus(3'd7, 3'b000, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, {1'b1, 32'd0});
        @(negedge clk);
        checkOutput("kind7_err", 32'(err), 32'd1);
        checkOutput("kind7_word_count", 32'(word_count), 32'd0);
        startLoad();
        sendModel(3'd5, 3'b000, 5'd2, 5'd3, 5'd0, 16'h8000, 26'd0, 1'b1);
        waitDone("after_err_done");

        // Reset in the middle of a streaming load
        startLoad();
        sendModel(3'd1, 3'b000, 5'd1, 5'd2, 5'd0, 16'h0004, 26'd0, 1'b0);
        sendModel(3'd2, 3'b000, 5'd1, 5'd2, 5'd0, 16'h0008, 26'd0, 1'b0);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_kind   = 3'd5;
        exp_q.delete();
        model_count = 0;
        @(negedge clk);
        checkResetValues("midreset");
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        startLoad();
        sendModel(3'd2, 3'b000, 5'd8, 5'd9, 5'd0, 16'h0020, 26'd0, 1'b1);
        waitDone("midreset_reload_done");
        checkOutput("midreset_reload_count", 32'(word_count), 32'd1);

        // Overflow on the 4-word instance
        startLoad();
        s_writes     = 0;
        s_done_count = 0;
        for (int i = 0; i < 5; i++) begin
            sendModel(3'd5, 3'b000, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 26'd0, (i == 4));
        end
        waitDone("ovf_big_done");
        checkOutput("ovf_big_word_count", 32'(word_count), 32'd5);
        checkOutput("ovf_small_writes", 32'(s_writes), 32'd4);
        checkOutput("ovf_small_last_addr", 32'(s_last_addr), 32'd3);
        checkOutput("ovf_small_addr_nowrap", 32'(s_imem_addr), 32'd3);
        checkOutput("ovf_small_err", 32'(s_err), 32'd1);
        checkOutput("ovf_small_no_done", 32'(s_done_count), 32'd0);
        checkOutput("ovf_small_word_count", 32'(s_word_count), 32'd4);
        checkOutput("ovf_small_in_ready", 32'(s_in_ready), 32'd0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
